alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Execute-stage ALU. Sits directly downstream of the ALU control decoder and consumes its 3-bit ALU control code plus the two operands from the ID/EX register.
- add, sub, and, or, addi (add) complete in one registered cycle.
- mul runs as an iterative shift-add over WIDTH cycles.
- During a mul it back-pressures the pipeline through ready_o/stall_o; the hazard unit uses stall_o to freeze IF/ID/EX.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  an operation is presented this cycle.
- ALUCtrl_i  input  3  op code: 000 add(addi), 001 sub, 010 mul, 011 and, 100 or, 101 add, 110/111 reserved.
- data1_i  input  WIDTH  operand A (rs1).
- data2_i  input  WIDTH  operand B (rs2 or sign-extended immediate).
- ready_o  output  1  block can accept an operation this cycle.
- valid_o  output  1  data_o holds a new result; single-cycle pulse per operation.
- data_o  output  WIDTH  result register.
- zero_o  output  1  data_o == 0; qualified by valid_o.
- stall_o  output  1  a mul is in flight; drives the pipeline freeze.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; valid_o=0; data_o=0; zero_o=1; stall_o=0; ready_o=1.
  - Multiplier registers and counter cleared.
  - A reset asserted mid-mul aborts the mul; no valid_o is produced for it.
- Accept: an operation is taken on a rising edge when valid_i && ready_o. ready_o = (state==IDLE).
- States: IDLE, MUL.
- IDLE, accepting a non-mul code:
  - data_o <= result; valid_o <= 1 for the next cycle only.
  - Stays in IDLE, so back-to-back single-cycle ops are accepted every cycle.
  - Arithmetic is modulo 2**WIDTH; no overflow flag. sub = A - B in two's complement.
  - Reserved codes 110/111 give result 0, valid_o pulses, no error.
- IDLE, accepting mul (010):
  - Latch mcand<=data1_i, mplier<=data2_i, acc<=0, cnt<=0.
  - Go to MUL; valid_o <= 0; ready_o=0 and stall_o=1 from the next cycle.
- MUL, each edge:
  - If mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1; cnt++.
- MUL exit:
  - On the edge where cnt==WIDTH-1, data_o <= the final acc value (including this iteration's add) and valid_o <= 1.
  - Return to IDLE; stall_o drops in the same cycle valid_o rises.
- Latency:
  - Non-mul: valid_o rises 1 cycle after accept.
  - mul: valid_o rises WIDTH cycles after accept. Result is the low WIDTH bits of the unsigned product, which equals the low half of the signed product.
- valid_i while in MUL is ignored; upstream must hold the instruction because stall_o=1.
- data_o holds its last value when valid_o=0. zero_o is recomputed from data_o every cycle.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: MUL also exits on the edge where the post-shift mplier is 0. data_o/valid_o are updated exactly as at normal exit, so latency = max(1, p+1) cycles, where p is the index of the highest set bit of data2_i. data2_i=0 gives 1 cycle.
- Undefined: latency is always WIDTH cycles, regardless of operands.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code constants ALU_ADD_I=3'b000, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_ADD. The ALU control decoder must use the same constants.
  - A state enum for IDLE/MUL.
- One natural sub-module: mul_shift_add, holding the mcand/mplier/acc/cnt datapath with start/done. alu_multicycle holds the FSM, single-cycle ops and output registers.

Test Plan:
- Reset mid-mul:
  - Stimulus: mul 7*9, then rst_i=1 two cycles after accept.
  - Required: all outputs return to reset values immediately; no valid_o for 63 after release.
  - Then sub 5-3: data_o=2, valid_o 1 cycle later.
- Back-to-back single-cycle ops:
  - Stimulus: add 0xFFFFFFFF+1, and 0xF0F0&0xFF00, or 0x1|0x2, sub 3-5, one per cycle.
  - Required: consecutive valid_o pulses with data_o = 0 (zero_o=1), 0xF000, 0x3, 0xFFFFFFFE.
- mul 12*13:
  - Required: ready_o=0 and stall_o=1 for WIDTH cycles; valid_o with data_o=156 exactly 32 cycles after accept.
  - With MUL_EARLY_EXIT_EN: 4 cycles.
- mul 0xFFFFFFFF*0xFFFFFFFF:
  - Required: data_o=0x00000001 after 32 cycles, with or without MUL_EARLY_EXIT_EN.
- valid_i held high with add 1+1 throughout a mul:
  - Required: the add is not accepted until the cycle ready_o returns to 1.
  - Its valid_o/data_o=2 arrives one cycle after the mul's valid_o.
- Reserved code 3'b111 with A=5, B=6:
  - Required: data_o=0, zero_o=1, valid_o pulses 1 cycle later, ready_o stays 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (also used by the ALU control
// decoder) and the execute-stage FSM state encoding.
package alu_pkg;

    // ALU control codes
    localparam logic [2:0] ALU_ADD_I = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_MUL   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_ADD   = 3'b101;

    // FSM state encodings
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = S_IDLE,
        ST_MUL  = S_MUL
    } alu_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier datapath: one multiplier bit per cycle.
// done_o/result_o are combinational and describe the iteration that
// completes on the coming edge, so the caller can register the final
// product on that same edge.
// Optional: `define MUL_EARLY_EXIT_EN to also finish once the shifted
// multiplier runs out of set bits.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;
    logic             last_iter;

    // Accumulator value after this cycle's conditional add, and exit detection
    always_comb begin
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
        done_o    = run_i && (last_iter || (mplier_q[WIDTH-1:1] == '0));
`else
        done_o    = run_i && last_iter;
`endif
        result_o  = acc_step;
    end

    // Load operands on start, otherwise advance one iteration while running
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (run_i) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle add/sub/and/or, multi-cycle mul with
// ready_o/stall_o back-pressure while the multiplier is busy.
// Optional: `define MUL_EARLY_EXIT_EN (handled in mul_shift_add).
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             stall_o
);

    alu_state_e       state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] single_res;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;

    assign accept    = valid_i && (state_q == ST_IDLE);
    assign mul_start = accept && (ALUCtrl_i == ALU_MUL);

    mul_shift_add #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (mul_start),
        .run_i    (state_q == ST_MUL),
        .mcand_i  (data1_i),
        .mplier_i (data2_i),
        .done_o   (mul_done),
        .result_o (mul_res)
    );

    // Single-cycle result; mul and reserved codes yield zero here
    always_comb begin
        single_res = '0;
        case (ALUCtrl_i)
            ALU_ADD_I, ALU_ADD: single_res = data1_i + data2_i;
            ALU_SUB:            single_res = data1_i - data2_i;
            ALU_AND:            single_res = data1_i & data2_i;
            ALU_OR:             single_res = data1_i | data2_i;
            default:            single_res = '0;
        endcase
    end

    // FSM and output register next-state; valid is a one-cycle pulse
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ALUCtrl_i == ALU_MUL) begin
                        state_d = ST_MUL;
                    end else begin
                        data_d  = single_res;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    data_d  = mul_res;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign stall_o = (state_q == ST_MUL);
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign zero_o  = (data_q == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: table of single-cycle vectors
// plus hand-written multi-cycle mul sequences.
module tb_alu_multicycle;
    import alu_pkg::*;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        zero_o;
    logic        stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_multicycle #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .stall_o   (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic v);
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        valid_i   = v;
    endtask

    // Issue a mul, count cycles to valid_o, check stall/ready throughout.
    // With hold_add, an add 1+1 is held on the inputs during the mul.
    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_lat, input bit hold_add);
        int lat;
        bit seen;
        bit bad_stall;
        lat = 0;
        seen = 1'b0;
        bad_stall = 1'b0;
        drive(ALU_MUL, a, b, 1'b1);
        @(posedge clk); #1;
        if (hold_add) drive(ALU_ADD, 32'd1, 32'd1, 1'b1);
        else          drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (stall_o !== 1'b1 || ready_o !== 1'b0) bad_stall = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (valid_o === 1'b1) seen = 1'b1;
        end
        chk({name, " latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        chk({name, " data"}, data_o, exp_res);
        chk({name, " zero"}, {31'd0, zero_o}, {31'd0, exp_res == 32'd0});
        chk({name, " stall during mul"}, {31'd0, bad_stall}, 32'd0);
        chk({name, " stall at done"}, {31'd0, stall_o}, 32'd0);
        chk({name, " ready at done"}, {31'd0, ready_o}, 32'd1);
        if (hold_add) begin
            @(posedge clk); #1;
            drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
            chk({name, " held add valid"}, {31'd0, valid_o}, 32'd1);
            chk({name, " held add data"}, data_o, 32'd2);
        end
        @(posedge clk); #1;
        chk({name, " valid pulse ends"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{ALU_ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
        vecs[1] = '{ALU_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
        vecs[2] = '{ALU_OR,    32'h1,         32'h2,         32'h3,         1'b0};
        vecs[3] = '{ALU_SUB,   32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
        vecs[4] = '{3'b111,    32'd5,         32'd6,         32'h0,         1'b1};
        vecs[5] = '{ALU_ADD_I, 32'd7,         32'd8,         32'd15,        1'b0};
        vecs[6] = '{3'b110,    32'd9,         32'd9,         32'h0,         1'b1};
        vecs[7] = '{ALU_ADD,   32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0};
        vecs[8] = '{ALU_SUB,   32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};
        vecs[9] = '{ALU_SUB,   32'd5,         32'd3,         32'd2,         1'b0};

        rst_i = 1'b1;
        drive(3'b000, 32'd0, 32'd0, 1'b0);
        #1;
        chk("reset valid", {31'd0, valid_o}, 32'd0);
        chk("reset data",  data_o, 32'd0);
        chk("reset zero",  {31'd0, zero_o}, 32'd1);
        chk("reset stall", {31'd0, stall_o}, 32'd0);
        chk("reset ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops, one accepted per cycle
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid", i), {31'd0, valid_o}, 32'd1);
            chk($sformatf("vec%0d data", i), data_o, vecs[i].exp_data);
            chk($sformatf("vec%0d zero", i), {31'd0, zero_o}, {31'd0, vecs[i].exp_zero});
            chk($sformatf("vec%0d ready", i), {31'd0, ready_o}, 32'd1);
        end
        drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        chk("idle valid low", {31'd0, valid_o}, 32'd0);
        chk("idle data holds", data_o, 32'd2);

        // Multi-cycle products
        run_mul("mul 12*13", 32'd12, 32'd13, 32'd156, EARLY ? 4 : 32, 1'b0);
        run_mul("mul ffff*ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32, 1'b0);
        run_mul("mul 5*0", 32'd5, 32'd0, 32'd0, EARLY ? 1 : 32, 1'b0);
        run_mul("mul 3*5 hold", 32'd3, 32'd5, 32'd15, EARLY ? 3 : 32, 1'b1);

        // Reset mid-mul aborts it
        drive(ALU_MUL, 32'd7, 32'd9, 1'b1);
        @(posedge clk); #1;
        drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b1;
        #1;
        chk("midmul rst valid", {31'd0, valid_o}, 32'd0);
        chk("midmul rst data",  data_o, 32'd0);
        chk("midmul rst zero",  {31'd0, zero_o}, 32'd1);
        chk("midmul rst stall", {31'd0, stall_o}, 32'd0);
        chk("midmul rst ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk); #1;
        rst_i = 1'b0;
        begin
            bit got_valid;
            got_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (valid_o === 1'b1 || stall_o === 1'b1) got_valid = 1'b1;
            end
            chk("aborted mul silent", {31'd0, got_valid}, 32'd0);
        end
        drive(ALU_SUB, 32'd5, 32'd3, 1'b1);
        @(posedge clk); #1;
        drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
        chk("post-rst sub valid", {31'd0, valid_o}, 32'd1);
        chk("post-rst sub data",  data_o, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
